// File: rtl/sigma_tile_pkg.sv
// Shared port identifiers and arbiter state type for the sigma tile memory path.
package sigma_tile_pkg;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic {ARB_UNLOCKED, ARB_LOCKED} arb_state_t;

endpackage

// File: rtl/sigma_tile_idfifo.sv
// Small FIFO of port IDs for outstanding reads; push and pop may coincide at any occupancy.
module sigma_tile_idfifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/sigma_tile_memarb.sv
// Round-robin 2:1 merge of instruction and data split-transaction ports onto one master port.
//   state        | meaning
//   ARB_UNLOCKED | free to pick a port each cycle by round-robin
//   ARB_LOCKED   | a forwarded request stalled; latched port held until mem_ack
module sigma_tile_memarb
  import sigma_tile_pkg::*;
#(
  parameter int RD_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_mem_req,
  input  logic        instr_mem_we,
  input  logic [31:0] instr_mem_addr,
  input  logic [31:0] instr_mem_wdata,
  input  logic [3:0]  instr_mem_be,
  output logic        instr_mem_ack,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,
  input  logic        data_mem_req,
  input  logic        data_mem_we,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_wdata,
  input  logic [3:0]  data_mem_be,
  output logic        data_mem_ack,
  output logic        data_mem_resp,
  output logic [31:0] data_mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        err_o
);

  arb_state_t state;
  logic       lock_port;
  logic       rr;
  logic       gnt;
  logic       sel_req;
  logic       throttle;
  logic       accepted;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic       head_port;

  always_comb begin
    gnt = PORT_INSTR;
    if (state == ARB_LOCKED)
      gnt = lock_port;
    else if (instr_mem_req && data_mem_req)
      gnt = rr;
    else if (data_mem_req)
      gnt = PORT_DATA;
  end

  assign sel_req   = (gnt == PORT_DATA) ? data_mem_req   : instr_mem_req;
  assign mem_we    = (gnt == PORT_DATA) ? data_mem_we    : instr_mem_we;
  assign mem_addr  = (gnt == PORT_DATA) ? data_mem_addr  : instr_mem_addr;
  assign mem_wdata = (gnt == PORT_DATA) ? data_mem_wdata : instr_mem_wdata;
  assign mem_be    = (gnt == PORT_DATA) ? data_mem_be    : instr_mem_be;

  // Reads wait while no ID slot is free; a response this cycle frees one.
  assign fifo_pop = mem_resp & ~fifo_empty;
  assign throttle = sel_req & ~mem_we & fifo_full & ~fifo_pop;
  assign mem_req  = sel_req & ~throttle & ~rst_i;

  assign accepted  = mem_req & mem_ack;
  assign fifo_push = accepted & ~mem_we;

  assign instr_mem_ack = accepted & (gnt == PORT_INSTR);
  assign data_mem_ack  = accepted & (gnt == PORT_DATA);

  assign instr_mem_rdata = mem_rdata;
  assign data_mem_rdata  = mem_rdata;
  assign instr_mem_resp  = fifo_pop & (head_port == PORT_INSTR);
  assign data_mem_resp   = fifo_pop & (head_port == PORT_DATA);

  sigma_tile_idfifo #(
    .WIDTH (1),
    .DEPTH (RD_DEPTH)
  ) u_idfifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .din   (gnt),
    .pop   (fifo_pop),
    .dout  (head_port),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ARB_UNLOCKED;
      lock_port <= PORT_INSTR;
      rr        <= PORT_INSTR;
      err_o     <= 1'b0;
    end else begin
      case (state)
        ARB_UNLOCKED: begin
          if (mem_req && !mem_ack) begin
            state     <= ARB_LOCKED;
            lock_port <= gnt;
          end
        end
        ARB_LOCKED: begin
          if (mem_ack) state <= ARB_UNLOCKED;
        end
        default: state <= ARB_UNLOCKED;
      endcase
      if (accepted) rr <= ~gnt;
      if (mem_resp && fifo_empty) err_o <= 1'b1;
    end
  end

endmodule

// File: doc/sigma_tile_memarb.md
# sigma_tile_memarb

Two-to-one arbiter merging the core's split-transaction instruction and data ports (two `MemSplit32` links) onto the single `MemSplit32` master port toward tile memory/interconnect. Sits directly downstream of the CPU (or the CPU stub) inside `sigma_tile`. Uses round-robin grant with lock-until-accept. Tracks outstanding reads in an ID FIFO so in-order read responses are steered back to the issuing port.

## Interface
Parameters:
- `RD_DEPTH`, 4: maximum outstanding reads; power of two, ≥2.

Ports:
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset; asynchronous, active-high.
- `instr_mem` MemSplit32.Slave: port 0, instruction fetch (`req, we, addr[31:0], wdata[31:0], be[3:0]` in; `ack, resp, rdata[31:0]` out).
- `data_mem` MemSplit32.Slave: port 1, load/store; same signals.
- `mem` MemSplit32.Master: merged downstream port.
- `err_o` out 1: sticky; set on a downstream `resp` with no outstanding read.

## Operation
- Transfer accepted on a port in the cycle `req & ack` is high. Writes (`we=1`) produce no response. Reads produce exactly one `resp` pulse later, in downstream order.
- Grant: `gnt` ∈ {0,1}. Round-robin pointer `rr` (reset 0) names the preferred port.
  - Unlocked, both requesting: grant `rr`.
  - Unlocked, one requesting: grant that one.
  - `rr` ← ~granted port on every accepted downstream transfer.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED → LOCKED when `mem.req & ~mem.ack`; latch `gnt`.
  - LOCKED → UNLOCKED on `mem.ack`.
  - In LOCKED, the latched port is forwarded even if the other port requests.
  - Upstream must hold `req` and payload stable until `ack`; this is not checked.
- Forwarding is combinational. `mem.{req,we,addr,wdata,be}` = granted port's signals. Granted port `ack = mem.ack & fwd`. Non-granted port `ack = 0`.
- Read throttle:
  - If the granted request is a read and the ID FIFO is full with no pop this cycle, `mem.req = 0`.
  - Throttling applies before lock evaluation, so a throttled request does not lock.
  - Writes are never throttled.
- ID FIFO (depth `RD_DEPTH`, 1-bit entries):
  - Push granted port ID on accepted read.
  - Pop on `mem.resp`.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
- Response steering: `rdata` broadcast to both ports. `resp` asserted only on the port whose ID is at the FIFO head, when `mem.resp=1` and the FIFO is non-empty.
- `mem.resp` with the FIFO empty: no upstream `resp`; `err_o` ← 1 until reset.

## Timing
- Request path is zero latency: upstream `req` → `mem.req` in the same cycle, `mem.ack` → upstream `ack` in the same cycle.
- Response path is zero latency: `mem.resp/rdata` → upstream `resp/rdata` in the same cycle.
- Reset values: `rr=0`, state UNLOCKED, FIFO empty (count 0, pointers 0), `err_o=0`.
  - With no upstream `req`: `mem.req=0`, both `ack=0`, both `resp=0`.
- FIFO pointers wrap modulo `RD_DEPTH`. Count width is `$clog2(RD_DEPTH)+1`.
- Reset mid-transaction drops all outstanding IDs. Responses arriving after reset raise `err_o`; the system must reset downstream together.
- Throughput: one accepted transfer per cycle when `mem.ack` is held high.

## Structure
- `sigma_tile_pkg`: `localparam PORT_INSTR=1'b0, PORT_DATA=1'b1`; `typedef enum logic {ARB_UNLOCKED, ARB_LOCKED} arb_state_t`.
- Sub-module `sigma_tile_idfifo`:
  - Parameters: width 1, depth `RD_DEPTH`.
  - Ports: `clk_i`, `rst_i`, `push`, `din`, `pop`, `dout`, `empty`, `full`.
- Top level holds the lock FSM, `rr`, the muxes and `err_o`.

## Test plan
- **Single read, port 1:** `data_mem` read `addr=0x100`; downstream acks in the same cycle and returns `resp` with `rdata=0xDEADBEEF` 2 cycles later → `data_mem.resp=1` with that data; `instr_mem.resp=0`.
- **Contention:** both ports issue reads every cycle, `mem.ack=1` → grants alternate 0,1,0,1 starting with port 0 after reset.
- **Lock:** port 1 write to `0x200` stalled 3 cycles (`mem.ack=0`) while port 0 requests → `mem.addr` stays `0x200` throughout; port 0 is granted in the cycle after the ack.
- **Throttle:** `RD_DEPTH=4`, 4 reads accepted with no response → 5th read held with `mem.req=0`. In the cycle `mem.resp=1` arrives, the 5th read forwards and is accepted; a write during the full condition passes immediately.
- **Ordering:** interleaved reads I,D,D,I → responses arrive on instr, data, data, instr ports in that order.
- **Error/reset:** `mem.resp` with empty FIFO → `err_o=1`, no upstream `resp`. Asserting `rst_i` asynchronously mid-stall → `err_o=0`, `mem.req=0` without a clock edge.
